// File: rtl/imm_pkg.sv
// Shared immediate-generation types, opcodes and field extraction.
// Used by the decoder and the buffered immediate pipe.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b111
  } imm_fmt_e;

  // Code reported for an unrecognised opcode when decoding automatically.
  localparam logic [2:0] FMT_BAD = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic [31:0] imm_field(
    input logic [31:0] ins,
    input logic [2:0]  fmt
  );
    logic        s;
    logic [31:0] v;
    s = ins[31];
    case (fmt)
      FMT_I:   v = {{20{s}}, ins[31:20]};
      FMT_S:   v = {{20{s}}, ins[31:25], ins[11:7]};
      FMT_B:   v = {{19{s}}, s, ins[7], ins[30:25],
                    ins[11:8], 1'b0};
      FMT_J:   v = {{11{s}}, s, ins[19:12], ins[20],
                    ins[30:21], 1'b0};
      FMT_U:   v = {ins[31:12], 12'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational format selection and XLEN sign extension.
// Illegal formats yield a zero immediate.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_src,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  logic [6:0]  w_op;
  logic [2:0]  w_auto;
  logic [31:0] w_imm32;

  assign w_op = i_instr[6:0];

  always_comb begin
    w_auto = FMT_BAD;
    unique case (1'b1)
      (w_op == OP_LOAD),
      (w_op == OP_IMM),
      (w_op == OP_JALR):   w_auto = FMT_I;
      (w_op == OP_STORE):  w_auto = FMT_S;
      (w_op == OP_BRANCH): w_auto = FMT_B;
      (w_op == OP_JAL):    w_auto = FMT_J;
      (w_op == OP_LUI),
      (w_op == OP_AUIPC):  w_auto = FMT_U;
      default:             w_auto = FMT_BAD;
    endcase
  end

  assign o_fmt = (AUTO_DECODE != 0) ? w_auto : i_src;

  // 100, 101 and 110 are the only unassigned codes.
  assign o_illegal = o_fmt[2] && (o_fmt[1:0] != 2'b11);

  assign w_imm32 = imm_field(i_instr, o_fmt);
  assign o_imm   = o_illegal ? '0
                 : XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry valid/ready output FIFO.
// One-cycle registered latency; no pass-through when full.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 2,
  parameter int AUTO_DECODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instr,
  input  logic [2:0]                 imm_src,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            imm,
  output logic [2:0]                 fmt,
  output logic                       illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [XLEN-1:0] r_imm [DEPTH];
  logic [2:0]      r_fmt [DEPTH];
  logic            r_ill [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_ill;

  imm_decode #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_dec (
    .i_instr   (instr),
    .i_src     (imm_src),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_ill)
  );

  assign in_ready  = r_count < FULL;
  assign out_valid = r_count != '0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_imm[r_wptr] <= w_imm;
      r_fmt[r_wptr] <= w_fmt;
      r_ill[r_wptr] <= w_ill;
    end
  end

  assign imm     = out_valid ? r_imm[r_rptr] : '0;
  assign fmt     = out_valid ? r_fmt[r_rptr] : '0;
  assign illegal = out_valid && r_ill[r_rptr];
  assign count   = r_count;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed cases plus random traffic
// on a default instance and a 64-bit, imm_src-driven, 3-deep instance.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_iv = 1'b0, a_or = 1'b0;
  logic        a_ir, a_ov, a_ill;
  logic [31:0] a_ins = '0, a_imm;
  logic [2:0]  a_src = '0, a_fmt;
  logic [1:0]  a_cnt;

  logic        b_iv = 1'b0, b_or = 1'b0;
  logic        b_ir, b_ov, b_ill;
  logic [31:0] b_ins = '0;
  logic [63:0] b_imm;
  logic [2:0]  b_src = '0, b_fmt;
  logic [1:0]  b_cnt;

  int total = 0;
  int bad = 0;
  bit a_done = 0;
  bit b_done = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    bit          ill;
    bit          fchk;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                          7'h6f, 7'h37, 7'h17, 7'h33};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_iv), .in_ready(a_ir),
    .instr(a_ins), .imm_src(a_src),
    .out_valid(a_ov), .out_ready(a_or),
    .imm(a_imm), .fmt(a_fmt), .illegal(a_ill),
    .count(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(3), .AUTO_DECODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_iv), .in_ready(b_ir),
    .instr(b_ins), .imm_src(b_src),
    .out_valid(b_ov), .out_ready(b_or),
    .imm(b_imm), .fmt(b_fmt), .illegal(b_ill),
    .count(b_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Reference: immediate as a signed integer built from field weights.
  function automatic exp_t model(
    input logic [31:0] w,
    input logic [2:0]  src,
    input bit          auto
  );
    exp_t e;
    longint r;
    int nb;
    logic [2:0] f;
    e.fchk = 1;
    if (auto) begin
      case (w[6:0])
        7'h03, 7'h13, 7'h67: f = 3'd0;
        7'h23:               f = 3'd1;
        7'h63:               f = 3'd2;
        7'h6f:               f = 3'd3;
        7'h37, 7'h17:        f = 3'd7;
        default: begin f = 3'd4; e.fchk = 0; end
      endcase
    end else begin
      f = src;
    end
    r = 0;
    nb = 0;
    case (f)
      3'd0: begin r = longint'(w[31:20]); nb = 12; end
      3'd1: begin
        r = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        nb = 12;
      end
      3'd2: begin
        r = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        nb = 13;
      end
      3'd3: begin
        r = longint'(w[31]) * 1048576
          + longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        nb = 21;
      end
      3'd7: begin r = longint'(w[31:12]) * 4096; nb = 32; end
      default: nb = 0;
    endcase
    e.ill = (nb == 0);
    if (nb != 0 && w[31]) r = r - (longint'(1) << nb);
    e.imm = 64'(r);
    e.fmt = f;
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = ops[k];
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic dir(input logic [31:0] w, input logic [2:0] s,
                     input logic [31:0] ea, input logic [2:0] fa,
                     input bit ia, input logic [63:0] eb,
                     input bit ib);
    a_iv = 1; b_iv = 1; a_ins = w; b_ins = w;
    b_src = s; a_src = ~s; a_or = 1; b_or = 1;
    @(negedge clk);
    a_iv = 0; b_iv = 0;
    chk("dir.a.valid", a_ov, 1);
    chk("dir.a.imm", a_imm, ea);
    if (!ia) chk("dir.a.fmt", a_fmt, fa);
    chk("dir.a.ill", a_ill, ia);
    chk("dir.b.valid", b_ov, 1);
    chk("dir.b.imm", b_imm, eb);
    chk("dir.b.fmt", b_fmt, s);
    chk("dir.b.ill", b_ill, ib);
    @(negedge clk);
  endtask

  task automatic drive_a(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("a.count", a_cnt, qa.size());
      chk("a.in_ready", a_ir, qa.size() < 2);
      chk("a.out_valid", a_ov, qa.size() != 0);
      a_iv = ($urandom_range(0, 3) != 0);
      a_ins = rnd_instr();
      a_src = 3'($urandom);
      #1;
      if (a_iv && a_ir) qa.push_back(model(a_ins, a_src, 1));
    end
    @(negedge clk);
    a_iv = 0;
    a_done = 1;
  endtask

  task automatic drive_b(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("b.count", b_cnt, qb.size());
      chk("b.in_ready", b_ir, qb.size() < 3);
      chk("b.out_valid", b_ov, qb.size() != 0);
      b_iv = ($urandom_range(0, 3) != 0);
      b_ins = rnd_instr();
      b_src = 3'($urandom);
      #1;
      if (b_iv && b_ir) qb.push_back(model(b_ins, b_src, 0));
    end
    @(negedge clk);
    b_iv = 0;
    b_done = 1;
  endtask

  task automatic mon_a(input int n);
    exp_t e;
    bit hold = 0;
    logic [35:0] ph = '0;
    for (int c = 0; c < n + 64; c++) begin
      @(negedge clk);
      a_or = a_done ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      #1;
      if (hold) chk("a.hold", {a_ov, a_imm, a_fmt}, ph);
      hold = a_ov && !a_or;
      ph = {a_ov, a_imm, a_fmt};
      if (a_ov && a_or) begin
        if (qa.size() == 0) begin
          chk("a.unexpected", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a.imm", a_imm, e.imm[31:0]);
          if (e.fchk) chk("a.fmt", a_fmt, e.fmt);
          chk("a.ill", a_ill, e.ill);
        end
      end
      if (a_done && qa.size() == 0 && !a_ov) break;
    end
    chk("a.drained", qa.size(), 0);
  endtask

  task automatic mon_b(input int n);
    exp_t e;
    bit hold = 0;
    logic [67:0] ph = '0;
    for (int c = 0; c < n + 64; c++) begin
      @(negedge clk);
      b_or = b_done ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      #1;
      if (hold) chk("b.hold", {b_ov, b_imm, b_fmt}, ph);
      hold = b_ov && !b_or;
      ph = {b_ov, b_imm, b_fmt};
      if (b_ov && b_or) begin
        if (qb.size() == 0) begin
          chk("b.unexpected", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b.imm", b_imm, e.imm);
          chk("b.fmt", b_fmt, e.fmt);
          chk("b.ill", b_ill, e.ill);
        end
      end
      if (b_done && qb.size() == 0 && !b_ov) break;
    end
    chk("b.drained", qb.size(), 0);
  endtask

  initial begin
    #1;
    chk("rst.a.count", a_cnt, 0);
    chk("rst.a.out_valid", a_ov, 0);
    chk("rst.a.in_ready", a_ir, 1);
    chk("rst.a.imm", a_imm, 0);
    chk("rst.a.fmt", a_fmt, 0);
    chk("rst.a.ill", a_ill, 0);
    chk("rst.b.count", b_cnt, 0);
    chk("rst.b.out_valid", b_ov, 0);
    chk("rst.b.in_ready", b_ir, 1);
    chk("rst.b.imm", b_imm, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    dir(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 3'd0, 0,
        64'hFFFFFFFFFFFFFFFF, 0);
    dir(32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 3'd2, 0,
        64'hFFFFFFFFFFFFFFFC, 0);
    dir(32'h123450B7, 3'b111, 32'h12345000, 3'd7, 0,
        64'h0000000012345000, 0);
    dir(32'hABCDE0B7, 3'b111, 32'hABCDE000, 3'd7, 0,
        64'hFFFFFFFFABCDE000, 0);
    dir(32'h00000033, 3'b101, 32'h0, 3'd0, 1, 64'h0, 1);
    dir(32'h00000033, 3'b110, 32'h0, 3'd0, 1, 64'h0, 1);

    a_or = 0; a_iv = 1; a_ins = 32'h00100093;
    @(negedge clk);
    chk("fill.count1", a_cnt, 1);
    a_ins = 32'h00200093;
    @(negedge clk);
    chk("fill.count2", a_cnt, 2);
    chk("fill.in_ready", a_ir, 0);
    chk("fill.headA", a_imm, 1);
    a_ins = 32'h00300093;
    @(negedge clk);
    chk("fill.held_count", a_cnt, 2);
    chk("fill.held_head", a_imm, 1);
    a_or = 1;
    @(negedge clk);
    chk("fill.headB", a_imm, 2);
    chk("fill.countB", a_cnt, 1);
    @(negedge clk);
    chk("fill.headC", a_imm, 3);
    chk("fill.countC", a_cnt, 1);
    a_iv = 0;
    @(negedge clk);
    chk("fill.empty", a_ov, 0);
    chk("fill.count0", a_cnt, 0);
    a_or = 0;

    fork
      drive_a(1500);
      mon_a(1500);
      drive_b(1500);
      mon_b(1500);
    join

    a_or = 0; a_iv = 1; a_ins = rnd_instr();
    @(negedge clk);
    @(negedge clk);
    a_iv = 0;
    chk("mrst.pre_count", a_cnt, 2);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mrst.count", a_cnt, 0);
    chk("mrst.out_valid", a_ov, 0);
    chk("mrst.in_ready", a_ir, 1);
    chk("mrst.imm", a_imm, 0);
    chk("mrst.fmt", a_fmt, 0);
    chk("mrst.ill", a_ill, 0);
    @(negedge clk);
    rst_n = 1;
    a_or = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mrst.no_delivery", a_ov, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 2, output buffer entries; legal range 1..8.
REQ-003 Parameter AUTO_DECODE, default 1, immediate format source: 1 = derived from instr opcode, 0 = taken from imm_src.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  instr/imm_src valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 instr  input  32  raw instruction word.
REQ-009 imm_src  input  3  format select, used only when AUTO_DECODE=0.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  consumer accepts head entry.
REQ-012 imm  output  XLEN  sign-extended immediate of head entry.
REQ-013 fmt  output  3  format code of head entry.
REQ-014 illegal  output  1  head entry had an unsupported format or opcode.
REQ-015 count  output  clog2(DEPTH+1)  occupied entries.

Function
REQ-016 Format codes SHALL be:
- 000 I
- 001 S
- 010 B
- 011 J
- 111 U
- 100, 101, 110: illegal
REQ-017 The immediate fields SHALL be:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- U: {instr[31:12], 12'b0}
REQ-018 All formats, including U, SHALL be sign-extended from instr[31] to XLEN bits.
REQ-019 With AUTO_DECODE=1, opcode instr[6:0] SHALL map as follows:
- 0000011, 0010011, 1100111 -> I
- 0100011 -> S
- 1100011 -> B
- 1101111 -> J
- 0110111, 0010111 -> U
- any other opcode -> illegal
REQ-020 An illegal entry SHALL store imm=0, fmt=the code supplied or derived, and illegal=1; it is still enqueued and delivered.
REQ-021 A word SHALL be accepted when in_valid && in_ready at a rising clk edge; its result SHALL be stored in the buffer.
REQ-022 in_ready SHALL equal (count < DEPTH); there is no same-cycle pass-through when the buffer is full.
REQ-023 out_valid SHALL equal (count != 0), and imm/fmt/illegal SHALL present the head entry.
REQ-024 A head entry SHALL be removed when out_valid && out_ready at a rising edge.
REQ-025 Latency: a word accepted at edge N into an empty buffer SHALL appear with out_valid=1 after edge N, i.e. a one-cycle registered latency.
REQ-026 Entries SHALL leave in acceptance order; read and write pointers SHALL wrap modulo DEPTH.
REQ-027 A simultaneous push and pop SHALL leave count unchanged. When count=DEPTH, no push occurs because in_ready=0.
REQ-028 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-029 imm_src SHALL be ignored when AUTO_DECODE=1.
REQ-030 Head outputs SHALL hold stable while out_valid && !out_ready.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously and immediately set:
- count=0, out_valid=0, in_ready=1
- imm=0, fmt=000, illegal=0
- both pointers to 0
REQ-032 A reset asserted mid-operation SHALL discard all buffered entries without delivering them.
REQ-033 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Structure
REQ-034 Package imm_pkg SHALL hold:
- the imm_fmt_e enum (I/S/B/J/U codes)
- the opcode constants
- the XLEN-agnostic field-extraction function
REQ-035 A combinational sub-module imm_decode SHALL perform format selection and extension.
REQ-036 imm_gen_pipe SHALL contain only the buffer, the pointers, count and the handshake logic.

Verification
REQ-037 AUTO_DECODE=1, instr=0xFFF00093, out_ready=1 -> next cycle imm=0xFFFFFFFF, fmt=000, illegal=0.
REQ-038 instr=0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=010; with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
REQ-039 U-type cases:
- instr=0x123450B7 -> imm=0x12345000, fmt=111
- XLEN=64, instr=0xABCDE0B7 -> imm=0xFFFFFFFFABCDE000
REQ-040 DEPTH=2, out_ready=0, push three words A, B, C:
- count reaches 2, in_ready=0, C is held
- raising out_ready delivers A, B, C in order
REQ-041 instr=0x00000033 (R-type) -> illegal=1, imm=0. With AUTO_DECODE=0 and imm_src=101 -> illegal=1.
REQ-042 count=2, then rst_n pulsed low mid-cycle -> out_valid=0 and count=0 before the next edge; no entry is delivered afterwards.
